piezo_tone_seq: RTL and testbench
=================================

Name: piezo_tone_seq

Overview:
Parametrised successor to the per-digit piezo tone generator. One shared half-period counter drives a square wave for the lowest-index held key, replacing the ten separate dividers whose outputs were ORed. It adds a melody mode that plays one of two built-in note sequences (win / fail feedback for the Bulls and Cows game), with a start/stop handshake and a busy flag. It sits between the game controller and keypad decoder on one side and the piezo pin on the other.

Parameters:
NUM_KEYS, 10, number of key inputs (1..15).
CNT_W, 16, half-period counter width.
KEY_HP, {1702,1911,2024,2272,2552,2863,3033,3405,3822,1516}, flattened NUM_KEYS*CNT_W half-period table. Key i uses slice [i*CNT_W +: CNT_W]: key0=1516, key1=3822, ... key9=1702.
DUR_W, 24, duration counter width.
NOTE_DUR, 5000000, cycles each melody note sounds (>=1).
GAP_DUR, 500000, silent cycles after each melody note (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key  in  NUM_KEYS  level key requests; bit i = key i
mel_start  in  1  one-cycle pulse, start melody
mel_sel  in  1  0 = win melody, 1 = fail melody; sampled with mel_start
mel_stop  in  1  one-cycle pulse, abort melody
piezo  out  1  square-wave drive
busy  out  1  melody in progress
note_idx  out  4  key index currently sounding
note_valid  out  1  note_idx is sounding

Behaviour:
- Reset (async, rst_n=0): state IDLE; piezo=0, busy=0, note_idx=0, note_valid=0; all counters 0.
- Tone engine:
  - Half-period counter hp_cnt counts 0..HP-1, where HP is the table entry for the active index.
  - At HP-1: piezo toggles and hp_cnt returns to 0, giving period 2*HP cycles.
  - On any change of active index, or entry into silence: hp_cnt=0 and piezo=0 on the next edge.
  - HP=0 is treated as silence.
- States: IDLE, KEY, MEL_NOTE, MEL_GAP.
- IDLE:
  - mel_start has priority: latch mel_sel, step=0, go to MEL_NOTE.
  - Otherwise, if any key bit is set: go to KEY.
- KEY:
  - Active index = lowest set bit of key, re-evaluated every cycle.
  - key==0: go to IDLE the next cycle, piezo forced 0.
  - mel_start: preempts keys and goes to MEL_NOTE.
- Melodies: 4-entry ROMs; code 4'hF = end.
  - win = 1,3,5,8.
  - fail = 5,3,1,F.
- MEL_NOTE:
  - Sound ROM[step] for NOTE_DUR cycles, then go to MEL_GAP (silent) for GAP_DUR cycles.
  - Then step+1. If step was 3 or the next code is F, go to IDLE.
  - An F code at step 0 also goes straight to IDLE.
- Busy and key handling:
  - busy=1 in MEL_NOTE and MEL_GAP.
  - mel_start while busy is ignored; the melody is not restarted.
  - Keys are ignored while busy.
- mel_stop while busy: next cycle IDLE, piezo=0, busy=0.
- Simultaneous mel_start and mel_stop in IDLE: start wins. While busy: stop wins.
- Outputs:
  - note_valid=1 in KEY, and in MEL_NOTE; 0 in MEL_GAP and IDLE.
  - note_idx holds the last index when note_valid=0.
  - All outputs are registered, with 1-cycle latency from the input change.
- Duration counter saturates nowhere; it reloads at each state entry.
- An out-of-range ROM code (>=NUM_KEYS, not F) is treated as a silent note of normal duration.

Test Plan:
1. Reset mid-tone (key1 held, pull rst_n low between edges) -> piezo, busy, note_valid are 0 immediately; toggles resume from hp_cnt=0 after release.
2. key=10'b0000000010 held -> piezo toggles every 3822 cycles, note_idx=1, note_valid=1; release -> piezo=0 the next cycle.
3. key=10'b0000001010 -> key1 wins (period 7644). Then drop bit1 -> switches to key3 (HP=3033) with hp_cnt reset and piezo=0 on the switch cycle.
4. NOTE_DUR=20, GAP_DUR=4, mel_start with mel_sel=0:
   - Expected: note_idx 1,3,5,8, each note_valid for 20 cycles with 4-cycle gaps; busy high for 96 cycles, then IDLE.
   - A second mel_start mid-melody has no effect.
5. mel_sel=1 with the same parameters -> three notes (5,3,1), busy 72 cycles; keys held throughout are silent until busy falls, then KEY state.
6. mel_stop during the second note -> busy=0 and piezo=0 next cycle. Simultaneous mel_start+mel_stop in IDLE -> melody starts.

Source files
------------

// File: rtl/piezo_tone_seq.sv
// Piezo tone generator: one shared half-period divider sounds the lowest held key,
// plus a two-melody sequencer (win / fail) with start/stop handshake and busy flag.
module piezo_tone_seq #(
  parameter int unsigned NUM_KEYS = 10,
  parameter int unsigned CNT_W    = 16,
  parameter logic [NUM_KEYS*CNT_W-1:0] KEY_HP = {
    16'd1702, 16'd1911, 16'd2024, 16'd2272, 16'd2552,
    16'd2863, 16'd3033, 16'd3405, 16'd3822, 16'd1516},
  parameter int unsigned DUR_W    = 24,
  parameter int unsigned NOTE_DUR = 5000000,
  parameter int unsigned GAP_DUR  = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                mel_start,
  input  logic                mel_sel,
  input  logic                mel_stop,
  output logic                piezo,
  output logic                busy,
  output logic [3:0]          note_idx,
  output logic                note_valid
);

  typedef enum logic [1:0] {StIdle, StKey, StMelNote, StMelGap} state_e;

  localparam logic [DUR_W-1:0] NoteLast = DUR_W'(NOTE_DUR - 1);
  localparam logic [DUR_W-1:0] GapLast  = DUR_W'(GAP_DUR - 1);
  localparam logic [3:0]       CodeEnd  = 4'hF;

  state_e            st_q, st_d;
  logic [1:0]        step_q, step_d;
  logic              sel_q, sel_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [CNT_W-1:0]  hp_cnt_q, hp_cnt_d;
  logic              piezo_q, piezo_d;
  logic              busy_q, busy_d;
  logic [3:0]        note_idx_q, act_d;
  logic              note_valid_q, nv_d;
  logic              snd_q, snd_d;
  logic [3:0]        low_idx;
  logic [CNT_W-1:0]  hp;

  // Built-in melodies; 4'hF terminates a sequence early.
  function automatic logic [3:0] mel_code(input logic sel, input logic [1:0] step);
    logic [3:0] c;
    case ({sel, step})
      3'b000:  c = 4'd1;
      3'b001:  c = 4'd3;
      3'b010:  c = 4'd5;
      3'b011:  c = 4'd8;
      3'b100:  c = 4'd5;
      3'b101:  c = 4'd3;
      3'b110:  c = 4'd1;
      default: c = CodeEnd;
    endcase
    return c;
  endfunction

  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (key[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    sel_d  = sel_q;
    dur_d  = dur_q;
    unique case (st_q)
      StIdle, StKey: begin
        if (mel_start) begin
          sel_d  = mel_sel;
          step_d = 2'd0;
          st_d   = (mel_code(mel_sel, 2'd0) == CodeEnd) ? StIdle : StMelNote;
        end else if (|key) begin
          st_d = StKey;
        end else begin
          st_d = StIdle;
        end
      end
      StMelNote: begin
        if (mel_stop) begin
          st_d = StIdle;
        end else if (dur_q == NoteLast) begin
          st_d = StMelGap;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      StMelGap: begin
        if (mel_stop) begin
          st_d = StIdle;
        end else if (dur_q == GapLast) begin
          step_d = step_q + 2'd1;
          if (step_q == 2'd3 || mel_code(sel_q, step_q + 2'd1) == CodeEnd) st_d = StIdle;
          else st_d = StMelNote;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
    endcase
    if (st_d != st_q) dur_d = '0;

    busy_d = (st_d == StMelNote) || (st_d == StMelGap);
    nv_d   = 1'b0;
    act_d  = note_idx_q;
    unique case (st_d)
      StKey: begin
        nv_d  = 1'b1;
        act_d = low_idx;
      end
      StMelNote: begin
        nv_d  = 1'b1;
        act_d = mel_code(sel_d, step_d);
      end
      default: ;
    endcase

    // Out-of-range indices and zero table entries both map to silence.
    hp = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (act_d == 4'(i)) hp = KEY_HP[i*CNT_W +: CNT_W];
    end
    snd_d = nv_d && (hp != '0);

    // Any new tone (state entry, index change, resume from silence) starts from phase 0.
    if (!snd_d || !snd_q || (act_d != note_idx_q) || (st_d != st_q)) begin
      hp_cnt_d = '0;
      piezo_d  = 1'b0;
    end else if (hp_cnt_q == hp - CNT_W'(1)) begin
      hp_cnt_d = '0;
      piezo_d  = ~piezo_q;
    end else begin
      hp_cnt_d = hp_cnt_q + CNT_W'(1);
      piezo_d  = piezo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= StIdle;
      step_q       <= 2'd0;
      sel_q        <= 1'b0;
      dur_q        <= '0;
      hp_cnt_q     <= '0;
      piezo_q      <= 1'b0;
      busy_q       <= 1'b0;
      note_idx_q   <= 4'd0;
      note_valid_q <= 1'b0;
      snd_q        <= 1'b0;
    end else begin
      st_q         <= st_d;
      step_q       <= step_d;
      sel_q        <= sel_d;
      dur_q        <= dur_d;
      hp_cnt_q     <= hp_cnt_d;
      piezo_q      <= piezo_d;
      busy_q       <= busy_d;
      note_idx_q   <= act_d;
      note_valid_q <= nv_d;
      snd_q        <= snd_d;
    end
  end

  assign piezo      = piezo_q;
  assign busy       = busy_q;
  assign note_idx   = note_idx_q;
  assign note_valid = note_valid_q;

endmodule

// File: tb/tb_piezo_tone_seq.sv
// Bench for piezo_tone_seq: directed and randomized stimulus checked every cycle
// against a time-based model of key tones and melody timing.
module tb_piezo_tone_seq;
  localparam int NK   = 10;
  localparam int ND   = 20;
  localparam int GD   = 4;
  localparam int SLOT = ND + GD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key = '0;
  logic          mel_start = 1'b0;
  logic          mel_sel = 1'b0;
  logic          mel_stop = 1'b0;
  logic          piezo, busy, note_valid;
  logic [3:0]    note_idx;

  piezo_tone_seq #(
    .NOTE_DUR(ND),
    .GAP_DUR (GD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .mel_start (mel_start),
    .mel_sel   (mel_sel),
    .mel_stop  (mel_stop),
    .piezo     (piezo),
    .busy      (busy),
    .note_idx  (note_idx),
    .note_valid(note_valid)
  );

  always #5 clk = ~clk;

  int hp_tab [NK] = '{1516, 3822, 3405, 3033, 2863, 2552, 2272, 2024, 1911, 1702};
  int mel_rom [2][4] = '{'{1, 3, 5, 8}, '{5, 3, 1, 15}};

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;

  // Model: mode 0 silent idle, 1 key tone, 2 melody; times count edges since entry.
  int mode = 0;
  int mel_t = 0;
  int key_t = 0;
  int last_idx = 0;
  int msel = 0;
  logic       e_pz, e_busy, e_nv;
  logic [3:0] e_idx;

  function automatic int mel_len(input int s);
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (mel_rom[s][i] == 15) break;
      n++;
    end
    return n * SLOT;
  endfunction

  function automatic int lowest(input logic [NK-1:0] k);
    for (int i = 0; i < NK; i++) if (k[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    int li, n, w;
    if (mode == 2) begin
      if (mel_stop) mode = 0;
      else begin
        mel_t++;
        if (mel_t >= mel_len(msel)) mode = 0;
      end
    end else if (mel_start) begin
      mode  = 2;
      msel  = int'(mel_sel);
      mel_t = 0;
    end else if (key != '0) begin
      li = lowest(key);
      if (mode != 1 || li != last_idx) key_t = 0;
      else key_t++;
      mode     = 1;
      last_idx = li;
    end else begin
      mode = 0;
    end
    e_busy = 1'b0;
    e_nv   = 1'b0;
    e_pz   = 1'b0;
    if (mode == 1) begin
      e_nv = 1'b1;
      e_pz = ((key_t / hp_tab[last_idx]) % 2) == 1;
    end else if (mode == 2) begin
      e_busy = 1'b1;
      n = mel_t / SLOT;
      w = mel_t % SLOT;
      if (w < ND) begin
        e_nv     = 1'b1;
        last_idx = mel_rom[msel][n];
        e_pz     = ((w / hp_tab[last_idx]) % 2) == 1;
      end
    end
    e_idx = 4'(last_idx);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc_n, obs, exp);
  endtask

  task automatic chk_all();
    chk("piezo", {3'b0, piezo}, {3'b0, e_pz});
    chk("busy", {3'b0, busy}, {3'b0, e_busy});
    chk("note_valid", {3'b0, note_valid}, {3'b0, e_nv});
    chk("note_idx", note_idx, e_idx);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
    chk_all();
    mel_start = 1'b0;
    mel_stop  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic model_reset();
    mode     = 0;
    last_idx = 0;
    e_pz     = 1'b0;
    e_busy   = 1'b0;
    e_nv     = 1'b0;
    e_idx    = 4'd0;
  endtask

  initial begin
    // Power-on reset.
    #3 rst_n = 1'b0;
    #1 model_reset();
    chk_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_all();

    // Key1 alone: period 2*3822, then reset asserted mid-tone.
    key = NK'(2);
    run(2 * 3822 + 20);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk_all();
    @(posedge clk);
    #1 chk_all();
    rst_n = 1'b1;
    run(4000);

    // key1 beats key3; dropping bit1 switches to key3 from phase 0; then release.
    key = NK'(10);
    run(7700);
    key = NK'(8);
    run(3100);
    key = '0;
    run(5);

    // Random key patterns with short silent gaps.
    for (int s = 0; s < 6; s++) begin
      key = NK'($urandom_range(1, 1023));
      run($urandom_range(20, 3000));
      if ($urandom_range(0, 1) == 1) begin
        key = '0;
        run($urandom_range(1, 5));
      end
    end
    key = '0;
    run(3);

    // Win melody; a second start mid-melody must be ignored.
    mel_sel   = 1'b0;
    mel_start = 1'b1;
    run(40);
    mel_sel   = 1'b1;
    mel_start = 1'b1;
    run(70);

    // Fail melody with keys held throughout; tone only after busy falls.
    key       = NK'($urandom_range(1, 1023));
    mel_sel   = 1'b1;
    mel_start = 1'b1;
    run(90);
    key = '0;
    run(3);

    // Stop during the second note.
    mel_sel   = 1'($urandom_range(0, 1));
    mel_start = 1'b1;
    run(SLOT + $urandom_range(0, ND - 1));
    mel_stop = 1'b1;
    run(5);

    // Simultaneous start and stop in idle: start wins.
    mel_sel   = 1'($urandom_range(0, 1));
    mel_start = 1'b1;
    mel_stop  = 1'b1;
    run(100);

    // Mixed random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) key = NK'($urandom_range(0, 1023));
      if ($urandom_range(0, 199) == 0) begin
        mel_start = 1'b1;
        mel_sel   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) mel_stop = 1'b1;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
